// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with anti-ghosting blanking,
// PWM brightness and leading-zero suppression. Outputs are registered, active-low.
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned LIT_CYCLES   = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BCD,
    input  logic [3:0] an_i,
    input  logic       digit_valid,
    input  logic       lz_en,
    input  logic [2:0] brightness,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic [0:0]  ST_BLANK   = 1'b0;
    localparam logic [0:0]  ST_LIT     = 1'b1;
    localparam logic [11:0] BLANK_LAST = 12'(BLANK_CYCLES - 1);
    localparam logic [11:0] LIT_LAST   = 12'(LIT_CYCLES - 1);
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;
    localparam logic [3:0]  CODE_MINUS = 4'hA;

    logic [3:0]  mem_q [4];
    logic [3:0]  mem_d [4];
    logic [0:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  pwm_q, pwm_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;

    logic [3:0] cur_code;
    logic       supp_2, supp_1, slot_on;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h3F;
            default: decode = SEG_OFF;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (digit_valid) begin
            case (an_i)
                4'b1110: mem_d[0] = BCD;
                4'b1101: mem_d[1] = BCD;
                4'b1011: mem_d[2] = BCD;
                4'b0111: mem_d[3] = BCD;
                default: ;
            endcase
        end

        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q + 12'd1;
        pwm_d   = pwm_q;
        if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_LIT;
                cnt_d   = 12'd0;
                pwm_d   = 3'd0;
            end
        end else begin
            pwm_d = pwm_q + 3'd1;
            if (cnt_q == LIT_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = 12'd0;
                ptr_d   = ptr_q + 2'd1;
            end
        end

        // Slot 1 is only dropped when the hundreds digit is also dropped.
        cur_code = mem_q[ptr_q];
        supp_2   = lz_en && (mem_q[2] == 4'h0);
        supp_1   = supp_2 && (mem_q[1] == 4'h0);
        case (ptr_q)
            2'd3:    slot_on = (cur_code == CODE_MINUS);
            2'd2:    slot_on = (cur_code <= CODE_MINUS) && !supp_2;
            2'd1:    slot_on = (cur_code <= CODE_MINUS) && !supp_1;
            default: slot_on = (cur_code <= CODE_MINUS);
        endcase

        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if ((state_q == ST_LIT) && (pwm_q <= brightness) && slot_on) begin
            seg_d = decode(cur_code);
            an_d  = ~(4'b0001 << ptr_q);
        end
    end

    // NOTE: the digit memory is only four nibbles and has defined reset contents, so it is reset like any other flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q[0] <= 4'h0;
            mem_q[1] <= 4'h0;
            mem_q[2] <= 4'h0;
            mem_q[3] <= 4'hF;
            state_q  <= ST_BLANK;
            ptr_q    <= 2'd0;
            cnt_q    <= 12'd0;
            pwm_q    <= 3'd0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
        end else begin
            mem_q    <= mem_d;
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
